hmi_arbiter: RTL and testbench

Controller that shares the single six-digit 7-segment display path and the keypad event stream among three requesters: operacional, setup and an alert source (timed messages/warnings).
- Grants ownership by fixed priority with a minimum hold time and a blanking gap on handover.
- Drives the display controller's packet/enable inputs from the granted source.
- Routes each keypad event only to the current owner.
- Sits between the lock's functional modules and the display controller/keypad decoder, on the 1 kHz system clock.

---
 rtl/hmi_arbiter_pkg.sv | 36 +++
 rtl/hmi_arbiter_if.sv | 46 ++++
 rtl/hmi_prio_pick.sv | 36 +++
 rtl/hmi_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_hmi_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/hmi_arbiter_pkg.sv
// hmi_arbiter_pkg: shared types for the display/keypad arbiter.
// Owner enum order doubles as priority rank (alert highest).
package hmi_arbiter_pkg;

    typedef logic [23:0] bcdPac_t;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_OP    = 2'd1,
        OWN_SETUP = 2'd2,
        OWN_ALERT = 2'd3
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWITCH = 2'd1,
        ST_OWN    = 2'd2
    } arb_state_e;

    localparam logic [2:0] GNT_NONE  = 3'b000;
    localparam logic [2:0] GNT_OP    = 3'b001;
    localparam logic [2:0] GNT_SETUP = 3'b010;
    localparam logic [2:0] GNT_ALERT = 3'b100;

    function automatic logic [2:0] owner_gnt(owner_e o);
        logic [2:0] g;
        unique case (o)
            OWN_OP:    g = GNT_OP;
            OWN_SETUP: g = GNT_SETUP;
            OWN_ALERT: g = GNT_ALERT;
            default:   g = GNT_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/hmi_arbiter_if.sv
// hmi_arbiter_if: requester/display/keypad bundle around the arbiter.
// slave = arbiter side, master = requesters, display and keypad side.
interface hmi_arbiter_if;
    import hmi_arbiter_pkg::*;

    logic       req_op;
    logic       req_setup;
    logic       req_alert;
    bcdPac_t    bcd_op;
    bcdPac_t    bcd_setup;
    bcdPac_t    bcd_alert;
    logic       en_op;
    logic       en_setup;
    logic       en_alert;
    logic       key_valid;
    logic [3:0] key_code;

    logic [2:0] grant;
    bcdPac_t    bcd_out;
    logic       bcd_enable;
    logic       key_valid_op;
    logic       key_valid_setup;
    logic [3:0] key_code_out;
    logic       key_dropped;

    modport master (
        output req_op, req_setup, req_alert,
        output bcd_op, bcd_setup, bcd_alert,
        output en_op, en_setup, en_alert,
        output key_valid, key_code,
        input  grant, bcd_out, bcd_enable,
        input  key_valid_op, key_valid_setup,
        input  key_code_out, key_dropped
    );

    modport slave (
        input  req_op, req_setup, req_alert,
        input  bcd_op, bcd_setup, bcd_alert,
        input  en_op, en_setup, en_alert,
        input  key_valid, key_code,
        output grant, bcd_out, bcd_enable,
        output key_valid_op, key_valid_setup,
        output key_code_out, key_dropped
    );

endinterface

// File: rtl/hmi_prio_pick.sv
// hmi_prio_pick: fixed-priority pick (alert > setup > op) among requesters
// ranked strictly above floor_own; a locked alert is never eligible.
module hmi_prio_pick
    import hmi_arbiter_pkg::*;
(
    input  logic   req_op,
    input  logic   req_setup,
    input  logic   req_alert,
    input  logic   alert_lock,
    input  owner_e floor_own,
    output owner_e pick
);

    logic el_alert;
    logic el_setup;
    logic el_op;
    logic win_alert;
    logic win_setup;
    logic win_op;

    always_comb begin
        el_alert  = req_alert && !alert_lock && (floor_own < OWN_ALERT);
        el_setup  = req_setup && (floor_own < OWN_SETUP);
        el_op     = req_op && (floor_own < OWN_OP);
        win_alert = el_alert;
        win_setup = el_setup && !el_alert;
        win_op    = el_op && !el_setup && !el_alert;
        unique case (1'b1)
            win_alert: pick = OWN_ALERT;
            win_setup: pick = OWN_SETUP;
            win_op:    pick = OWN_OP;
            default:   pick = OWN_NONE;
        endcase
    end

endmodule

// File: rtl/hmi_arbiter.sv
// hmi_arbiter: shares the 7-segment display and keypad among op/setup/alert.
// Define HMI_ARB_PREEMPT_EN to let alert take over without waiting HOLD_MS.
module hmi_arbiter
    import hmi_arbiter_pkg::*;
#(
    parameter int HOLD_MS      = 200,
    parameter int BLANK_CYCLES = 2,
    parameter int ALERT_MAX_MS = 3000
) (
    input logic          clk,
    input logic          rst,
    hmi_arbiter_if.slave hmi
);

    localparam int CNT_MAX =
        (HOLD_MS > ALERT_MAX_MS) ? HOLD_MS : ALERT_MAX_MS;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_C   = CW'(CNT_MAX);
    localparam logic [CW-1:0] HOLD_C  = CW'(HOLD_MS);
    localparam logic [CW-1:0] ALERT_C = CW'(ALERT_MAX_MS);
    localparam logic [3:0] BLANK_LAST = 4'(BLANK_CYCLES - 1);

    arb_state_e    state;
    arb_state_e    nx_state;
    owner_e        owner;
    owner_e        nx_owner;
    owner_e        floor_own;
    owner_e        pick;
    logic [CW-1:0] own_cnt;
    logic [3:0]    blank_cnt;
    logic          alert_lock;
    logic          lock_eff;
    logic          kbuf_v;
    logic [3:0]    kbuf_code;
    logic          kbuf_nv;
    logic [3:0]    kbuf_nc;

    logic          owner_req;
    bcdPac_t       own_bcd;
    logic          own_en;
    logic          switch_done;
    logic          alert_timeout;
    logic          hold_ok;

    logic          key_go;
    owner_e        key_dst;
    logic [3:0]    key_cd;
    logic          drop_now;

    logic [2:0]    grant_q;
    bcdPac_t       bcd_q;
    logic          en_q;
    logic          kv_op_q;
    logic          kv_setup_q;
    logic [3:0]    kc_q;
    logic          kd_q;

    always_comb begin
        unique case (owner)
            OWN_OP: begin
                owner_req = hmi.req_op;
                own_bcd   = hmi.bcd_op;
                own_en    = hmi.en_op;
            end
            OWN_SETUP: begin
                owner_req = hmi.req_setup;
                own_bcd   = hmi.bcd_setup;
                own_en    = hmi.en_setup;
            end
            OWN_ALERT: begin
                owner_req = hmi.req_alert;
                own_bcd   = hmi.bcd_alert;
                own_en    = hmi.en_alert;
            end
            default: begin
                owner_req = 1'b0;
                own_bcd   = '0;
                own_en    = 1'b0;
            end
        endcase
    end

    assign switch_done = (state == ST_SWITCH) && (blank_cnt == BLANK_LAST);
    assign alert_timeout = (state == ST_OWN) && (owner == OWN_ALERT)
                         && (own_cnt == ALERT_C);
    assign lock_eff = alert_lock || alert_timeout;

    // While an owner holds the display only higher ranks may compete.
    assign floor_own = (state == ST_OWN && owner_req && !alert_timeout)
                     ? owner : OWN_NONE;

`ifdef HMI_ARB_PREEMPT_EN
    assign hold_ok = (own_cnt >= HOLD_C) || (pick == OWN_ALERT);
`else
    assign hold_ok = (own_cnt >= HOLD_C);
`endif

    hmi_prio_pick u_pick (
        .req_op     (hmi.req_op),
        .req_setup  (hmi.req_setup),
        .req_alert  (hmi.req_alert),
        .alert_lock (lock_eff),
        .floor_own  (floor_own),
        .pick       (pick)
    );

    always_comb begin
        nx_state = state;
        nx_owner = owner;
        unique case (state)
            ST_IDLE: begin
                if (pick != OWN_NONE) begin
                    nx_state = ST_SWITCH;
                    nx_owner = pick;
                end
            end
            ST_SWITCH: begin
                if (switch_done) begin
                    if (owner_req) begin
                        nx_state = ST_OWN;
                    end else if (pick != OWN_NONE) begin
                        nx_owner = pick;
                    end else begin
                        nx_state = ST_IDLE;
                        nx_owner = OWN_NONE;
                    end
                end
            end
            ST_OWN: begin
                if (!owner_req || alert_timeout) begin
                    nx_state = (pick != OWN_NONE) ? ST_SWITCH : ST_IDLE;
                    nx_owner = pick;
                end else if (pick != OWN_NONE && hold_ok) begin
                    nx_state = ST_SWITCH;
                    nx_owner = pick;
                end
            end
            default: begin
                nx_state = ST_IDLE;
                nx_owner = OWN_NONE;
            end
        endcase
    end

    // Keys seen during a handover wait in a 1-deep buffer for the new owner.
    always_comb begin
        key_go   = 1'b0;
        key_dst  = OWN_NONE;
        key_cd   = hmi.key_code;
        drop_now = 1'b0;
        kbuf_nv  = kbuf_v;
        kbuf_nc  = kbuf_code;
        unique case (state)
            ST_IDLE: begin
                key_go  = hmi.key_valid;
                key_dst = OWN_OP;
            end
            ST_OWN: begin
                key_go  = hmi.key_valid;
                key_dst = owner;
            end
            ST_SWITCH: begin
                drop_now = hmi.key_valid && kbuf_v;
                if (nx_state == ST_SWITCH) begin
                    if (hmi.key_valid) begin
                        kbuf_nv = 1'b1;
                        kbuf_nc = hmi.key_code;
                    end
                end else begin
                    kbuf_nv = 1'b0;
                    key_go  = hmi.key_valid || kbuf_v;
                    key_cd  = hmi.key_valid ? hmi.key_code : kbuf_code;
                    key_dst = (nx_state == ST_OWN) ? owner : OWN_OP;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            owner      <= OWN_NONE;
            grant_q    <= GNT_NONE;
            blank_cnt  <= '0;
            own_cnt    <= '0;
            alert_lock <= 1'b0;
            bcd_q      <= '0;
            en_q       <= 1'b0;
            kbuf_v     <= 1'b0;
            kbuf_code  <= '0;
            kv_op_q    <= 1'b0;
            kv_setup_q <= 1'b0;
            kc_q       <= '0;
            kd_q       <= 1'b0;
        end else begin
            state   <= nx_state;
            owner   <= nx_owner;
            grant_q <= owner_gnt(nx_owner);
            if (state == ST_SWITCH && !switch_done) begin
                blank_cnt <= blank_cnt + 4'd1;
            end else begin
                blank_cnt <= '0;
            end
            if (state == ST_OWN && nx_state == ST_OWN) begin
                if (own_cnt != CNT_C) begin
                    own_cnt <= own_cnt + CW'(1);
                end
            end else begin
                own_cnt <= '0;
            end
            if (alert_timeout) begin
                alert_lock <= 1'b1;
            end else if (!hmi.req_alert) begin
                alert_lock <= 1'b0;
            end
            if (nx_state == ST_OWN) begin
                bcd_q <= own_bcd;
                en_q  <= own_en;
            end else begin
                bcd_q <= '0;
                en_q  <= 1'b0;
            end
            kbuf_v     <= kbuf_nv;
            kbuf_code  <= kbuf_nc;
            kv_op_q    <= key_go && (key_dst == OWN_OP);
            kv_setup_q <= key_go && (key_dst == OWN_SETUP);
            kd_q       <= drop_now || (key_go && key_dst == OWN_ALERT);
            if (key_go && (key_dst == OWN_OP || key_dst == OWN_SETUP)) begin
                kc_q <= key_cd;
            end
        end
    end

    assign hmi.grant           = grant_q;
    assign hmi.bcd_out         = bcd_q;
    assign hmi.bcd_enable      = en_q;
    assign hmi.key_valid_op    = kv_op_q;
    assign hmi.key_valid_setup = kv_setup_q;
    assign hmi.key_code_out    = kc_q;
    assign hmi.key_dropped     = kd_q;

endmodule

// File: tb/tb_hmi_arbiter.sv
// tb_hmi_arbiter: vector table with scoreboard plus hold/timeout/reset sequences.
// Build with HMI_ARB_PREEMPT_EN defined to check the alert-preempt variant.
module tb_hmi_arbiter;
    import hmi_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hmi_arbiter_if hmi ();

    hmi_arbiter dut (
        .clk (clk),
        .rst (rst),
        .hmi (hmi)
    );

`ifdef HMI_ARB_PREEMPT_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    localparam logic [23:0] BA = 24'h123456;
    localparam logic [23:0] BS = 24'h654321;
    localparam logic [23:0] BL = 24'h999999;
    localparam logic [23:0] BC = 24'habcdef;

    typedef struct {
        logic        op, su, al, kv;
        logic [3:0]  kc;
        logic [23:0] bop;
        logic        eno;
        logic [2:0]  g;
        logic        en;
        logic [23:0] b;
        logic        kvo, kvs;
        logic [3:0]  kco;
        logic        kd;
    } vec_t;

    typedef struct {
        int          due;
        int          row;
        logic [34:0] exp;
    } sb_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    sb_t  sbq[$];
    vec_t tbl[27];

    function automatic logic [34:0] outs();
        return {hmi.grant, hmi.bcd_enable, hmi.bcd_out, hmi.key_valid_op,
                hmi.key_valid_setup, hmi.key_code_out, hmi.key_dropped};
    endfunction

    function automatic vec_t mk(
        input logic op, su, al, kv, input logic [3:0] kc,
        input logic [23:0] bop, input logic eno, input logic [2:0] g,
        input logic en, input logic [23:0] b, input logic kvo, kvs,
        input logic [3:0] kco, input logic kd);
        vec_t v;
        v.op = op; v.su = su; v.al = al; v.kv = kv; v.kc = kc;
        v.bop = bop; v.eno = eno; v.g = g; v.en = en; v.b = b;
        v.kvo = kvo; v.kvs = kvs; v.kco = kco; v.kd = kd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        chk("onehot_excl",
            {63'd0, $onehot0(hmi.grant)
                && !(hmi.key_valid_op && hmi.key_valid_setup)}, 64'd1);
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            sb_t e;
            e = sbq.pop_front();
            chk($sformatf("row%0d", e.row), 64'(outs()), 64'(e.exp));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        logic seen;

        rst = 1'b0;
        hmi.req_op = 0; hmi.req_setup = 0; hmi.req_alert = 0;
        hmi.bcd_op = BA; hmi.bcd_setup = BS; hmi.bcd_alert = BL;
        hmi.en_op = 1; hmi.en_setup = 1; hmi.en_alert = 1;
        hmi.key_valid = 0; hmi.key_code = 4'h0;

        //           op su al kv kc    bop eno  g       en b   kvo kvs kco   kd
        tbl[0]  = mk(0, 0, 0, 1, 4'h3, BA, 1, 3'b000, 0, 0,  1, 0, 4'h3, 0);
        tbl[1]  = mk(1, 0, 0, 0, 4'h0, BA, 1, 3'b001, 0, 0,  0, 0, 4'h3, 0);
        tbl[2]  = mk(1, 0, 0, 1, 4'h7, BA, 1, 3'b001, 0, 0,  0, 0, 4'h3, 0);
        tbl[3]  = mk(1, 0, 0, 1, 4'h9, BA, 1, 3'b001, 1, BA, 1, 0, 4'h9, 1);
        tbl[4]  = mk(1, 0, 0, 1, 4'h5, BA, 1, 3'b001, 1, BA, 1, 0, 4'h5, 0);
        tbl[5]  = mk(1, 0, 0, 0, 4'h0, BC, 0, 3'b001, 0, BC, 0, 0, 4'h5, 0);
        tbl[6]  = mk(0, 0, 0, 1, 4'h2, BA, 1, 3'b000, 0, 0,  1, 0, 4'h2, 0);
        tbl[7]  = mk(0, 0, 0, 0, 4'h0, BA, 1, 3'b000, 0, 0,  0, 0, 4'h2, 0);
        tbl[8]  = mk(0, 1, 0, 0, 4'h0, BA, 1, 3'b010, 0, 0,  0, 0, 4'h2, 0);
        tbl[9]  = mk(0, 1, 0, 1, 4'h7, BA, 1, 3'b010, 0, 0,  0, 0, 4'h2, 0);
        tbl[10] = mk(0, 1, 0, 0, 4'h0, BA, 1, 3'b010, 1, BS, 0, 1, 4'h7, 0);
        tbl[11] = mk(0, 1, 0, 1, 4'h4, BA, 1, 3'b010, 1, BS, 0, 1, 4'h4, 0);
        tbl[12] = mk(1, 1, 0, 0, 4'h0, BA, 1, 3'b010, 1, BS, 0, 0, 4'h4, 0);
        tbl[13] = mk(1, 0, 0, 0, 4'h0, BA, 1, 3'b001, 0, 0,  0, 0, 4'h4, 0);
        tbl[14] = mk(1, 0, 0, 0, 4'h0, BA, 1, 3'b001, 0, 0,  0, 0, 4'h4, 0);
        tbl[15] = mk(1, 0, 0, 0, 4'h0, BA, 1, 3'b001, 1, BA, 0, 0, 4'h4, 0);
        tbl[16] = mk(0, 0, 1, 0, 4'h0, BA, 1, 3'b100, 0, 0,  0, 0, 4'h4, 0);
        tbl[17] = mk(0, 0, 1, 0, 4'h0, BA, 1, 3'b100, 0, 0,  0, 0, 4'h4, 0);
        tbl[18] = mk(0, 0, 1, 1, 4'h6, BA, 1, 3'b100, 1, BL, 0, 0, 4'h4, 1);
        tbl[19] = mk(0, 0, 1, 1, 4'h8, BA, 1, 3'b100, 1, BL, 0, 0, 4'h4, 1);
        tbl[20] = mk(0, 0, 0, 0, 4'h0, BA, 1, 3'b000, 0, 0,  0, 0, 4'h4, 0);
        tbl[21] = mk(1, 0, 0, 0, 4'h0, BA, 1, 3'b001, 0, 0,  0, 0, 4'h4, 0);
        tbl[22] = mk(0, 1, 0, 0, 4'h0, BA, 1, 3'b001, 0, 0,  0, 0, 4'h4, 0);
        tbl[23] = mk(0, 1, 0, 0, 4'h0, BA, 1, 3'b010, 0, 0,  0, 0, 4'h4, 0);
        tbl[24] = mk(0, 1, 0, 1, 4'h1, BA, 1, 3'b010, 0, 0,  0, 0, 4'h4, 0);
        tbl[25] = mk(0, 1, 0, 0, 4'h0, BA, 1, 3'b010, 1, BS, 0, 1, 4'h1, 0);
        tbl[26] = mk(0, 0, 0, 1, 4'hb, BA, 1, 3'b000, 0, 0,  0, 1, 4'hb, 0);

        #12;
        chk("reset_state", 64'(outs()), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 27; i++) begin
            hmi.req_op    = tbl[i].op;
            hmi.req_setup = tbl[i].su;
            hmi.req_alert = tbl[i].al;
            hmi.key_valid = tbl[i].kv;
            hmi.key_code  = tbl[i].kc;
            hmi.bcd_op    = tbl[i].bop;
            hmi.en_op     = tbl[i].eno;
            sbq.push_back('{due: cyc + 1, row: i,
                            exp: {tbl[i].g, tbl[i].en, tbl[i].b, tbl[i].kvo,
                                  tbl[i].kvs, tbl[i].kco, tbl[i].kd}});
            step();
        end
        hmi.key_valid = 0;
        hmi.req_op = 0; hmi.req_setup = 0; hmi.req_alert = 0;
        hmi.bcd_op = BA; hmi.en_op = 1;

        // Async reset in the middle of a handover.
        hmi.req_op = 1;
        step();
        chk("switch_grant", 64'(hmi.grant), 64'(GNT_OP));
        #3;
        rst = 1'b0;
        #1;
        chk("rst_mid_switch", 64'(outs()), 64'd0);
        hmi.req_op = 0;
        @(negedge clk);
        rst = 1'b1;

        // Op owns; setup must wait for the hold time.
        hmi.req_op = 1;
        step();
        step();
        step();
        for (int c = 0; c <= 200; c++) begin
            hmi.req_setup = (c >= 50);
            step();
            if (c == 60 || c == 199)
                chk($sformatf("hold_wait%0d", c), 64'(hmi.grant), 64'(GNT_OP));
            if (c == 200)
                chk("hold_switch", 64'(hmi.grant), 64'(GNT_SETUP));
        end
        step();
        chk("blank_gap", 64'(hmi.bcd_enable), 64'd0);
        step();
        chk("setup_own", 64'({hmi.grant, hmi.bcd_enable, hmi.bcd_out}),
            64'({GNT_SETUP, 1'b1, BS}));

        // Alert arrives at own_cnt = 10 of setup ownership.
        for (int d = 0; d < 10; d++) step();
        hmi.req_alert = 1;
        step();
        chk("alert_take", 64'(hmi.grant), PRE ? 64'(GNT_ALERT) : 64'(GNT_SETUP));
        n = 0;
        while (hmi.grant != GNT_ALERT && n < 400) begin
            step();
            n++;
        end
        chk("alert_wait", 64'(n), PRE ? 64'd0 : 64'd190);

        // Forced release after the alert window, then lockout.
        hmi.req_op = 0;
        hmi.req_setup = 0;
        cnt = 1;
        for (int k = 0; k < 4000; k++) begin
            step();
            if (hmi.grant == GNT_ALERT) cnt++;
            else break;
        end
        chk("alert_window", 64'(cnt), 64'd3003);
        chk("alert_release", 64'(hmi.grant), 64'(GNT_NONE));
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (hmi.grant != GNT_NONE) seen = 1'b1;
        end
        chk("alert_locked", 64'(seen), 64'd0);
        hmi.req_alert = 0;
        step();
        chk("alert_low", 64'(hmi.grant), 64'(GNT_NONE));
        hmi.req_alert = 1;
        step();
        chk("alert_regrant", 64'(hmi.grant), 64'(GNT_ALERT));

        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
